regfile_write_arbiter: RTL and testbench

- Shares the single register-file write port (regwrite/wa/wd) among NREQ writeback requesters, e.g. ALU, load unit and multi-cycle unit.
- Each requester uses a valid/ready handshake; one write is accepted per cycle under round-robin priority.
- Sits between the execution/writeback units and the register file.
- Filters writes the register file must not see: $0, and addresses at or above NUM_REGS.

---
 rtl/regfile_write_arbiter.sv | 80 ++++++++
 tb/tb_regfile_write_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing one register-file write port; REGFILE_ARB_COMB_OUT_EN selects unregistered outputs
module regfile_write_arbiter #(
  parameter int NREQ     = 3,
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 5,
  parameter int NUM_REGS = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_data,
  output logic                     regwrite,
  output logic [ADDR_W-1:0]        wa,
  output logic [DATA_W-1:0]        wd,
  output logic                     err_oor,
  output logic [2:0]               grant_id
);
  logic [2:0] ptr, gid;
  logic hit, grant, in_range, fwd, oor;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  // first valid requester at or after ptr, wrapping
  always_comb begin
    hit = 1'b0;
    gid = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!hit && req_valid[(int'(ptr) + k) % NREQ]) begin
        hit = 1'b1;
        gid = 3'((int'(ptr) + k) % NREQ);
      end
    end
  end
  assign grant     = hit && !rst;
  assign req_ready = grant ? (NREQ'(1) << gid) : '0;
  assign grant_id  = grant ? gid : '0;
  assign sel_addr  = req_addr[gid*ADDR_W +: ADDR_W];
  assign sel_data  = req_data[gid*DATA_W +: DATA_W];
  assign in_range  = {1'b0, sel_addr} < (ADDR_W+1)'(NUM_REGS);
  assign fwd       = grant && sel_addr != '0 && in_range;
  assign oor       = grant && !in_range;
  // rotate priority past the winner; sticky out-of-range flag
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr     <= '0;
      err_oor <= 1'b0;
    end else begin
      if (grant) ptr <= (gid == 3'(NREQ-1)) ? '0 : gid + 3'd1;
      if (oor) err_oor <= 1'b1;
    end
  end
`ifdef REGFILE_ARB_COMB_OUT_EN
  assign regwrite = fwd;
  assign wa       = fwd ? sel_addr : '0;
  assign wd       = fwd ? sel_data : '0;
`else
  logic wr_q;
  logic [ADDR_W-1:0] wa_q;
  logic [DATA_W-1:0] wd_q;
  // write stage; wa/wd hold their last values when nothing is forwarded
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q <= 1'b0;
      wa_q <= '0;
      wd_q <= '0;
    end else begin
      wr_q <= fwd;
      if (fwd) begin
        wa_q <= sel_addr;
        wd_q <= sel_data;
      end
    end
  end
  // a pending write is dropped as soon as reset is seen
  assign regwrite = wr_q && !rst;
  assign wa       = wa_q;
  assign wd       = wd_q;
`endif
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed checks of arbitration, filtering, latency and reset
module tb_regfile_write_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic [2:0]  req_valid, req_ready;
  logic [14:0] req_addr;
  logic [23:0] req_data;
  logic regwrite, err_oor;
  logic [4:0] wa;
  logic [7:0] wd;
  logic [2:0] grant_id;
  logic [7:0] rf [8] = '{default: 8'h00};
  int tests = 0;
  int fails = 0;

  regfile_write_arbiter dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .regwrite(regwrite),
    .wa(wa), .wd(wd), .err_oor(err_oor), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (regwrite && wa < 5'd8) rf[wa[2:0]] <= wd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [7:0] d);
    req_valid[i] = v;
    req_addr[i*5 +: 5] = a;
    req_data[i*8 +: 8] = d;
  endtask

  task automatic cyc;
    @(negedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] exp_d [3];
    exp_d = '{8'h11, 8'h22, 8'h44};
    rst = 1'b1;
    req_valid = '0;
    req_addr = '0;
    req_data = '0;
    cyc();
    cyc();
    chk("reset_regwrite", regwrite, 0);
    chk("reset_ready", req_ready, 0);
    chk("reset_err", err_oor, 0);
    chk("reset_wa", wa, 0);
    chk("reset_wd", wd, 0);
    rst = 1'b0;
`ifndef REGFILE_ARB_COMB_OUT_EN
    set_req(1, 1'b1, 5'd3, 8'hA5);
    #1;
    chk("single_ready", req_ready, 3'b010);
    chk("single_gid", grant_id, 1);
    chk("single_no_same_cycle_write", regwrite, 0);
    cyc();
    set_req(1, 1'b0, 5'd0, 8'h00);
    chk("single_regwrite", regwrite, 1);
    chk("single_wa", wa, 3);
    chk("single_wd", wd, 8'hA5);
    cyc();
    chk("single_idle_regwrite", regwrite, 0);
    chk("single_wa_hold", wa, 3);
    chk("rf3", rf[3], 8'hA5);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    set_req(0, 1'b1, 5'd1, 8'h11);
    set_req(1, 1'b1, 5'd2, 8'h22);
    set_req(2, 1'b1, 5'd4, 8'h44);
    #1;
    for (int k = 0; k < 6; k++) begin
      chk("rot_gid", grant_id, k % 3);
      chk("rot_ready", req_ready, 3'b001 << (k % 3));
      if (k > 0) begin
        chk("rot_regwrite", regwrite, 1);
        chk("rot_wd", wd, exp_d[(k-1) % 3]);
      end
      cyc();
    end
    req_valid = '0;
    chk("rot_last_regwrite", regwrite, 1);
    chk("rot_last_wd", wd, 8'h44);
    chk("rot_last_wa", wa, 4);
    cyc();
    chk("rf1", rf[1], 8'h11);
    chk("rf2", rf[2], 8'h22);
    chk("rf4", rf[4], 8'h44);
    set_req(0, 1'b1, 5'd0, 8'hFF);
    #1;
    chk("zero_ready", req_ready, 3'b001);
    cyc();
    req_valid = '0;
    chk("zero_no_write", regwrite, 0);
    chk("zero_no_err", err_oor, 0);
    cyc();
    chk("rf0", rf[0], 0);
    set_req(2, 1'b1, 5'd9, 8'h77);
    #1;
    chk("oor_ready", req_ready, 3'b100);
    chk("oor_gid", grant_id, 2);
    cyc();
    req_valid = '0;
    chk("oor_no_write", regwrite, 0);
    chk("oor_err", err_oor, 1);
    cyc();
    cyc();
    chk("oor_err_sticky", err_oor, 1);
    set_req(0, 1'b1, 5'd5, 8'h5A);
    #1;
    chk("mid_ready", req_ready, 3'b001);
    cyc();
    set_req(0, 1'b0, 5'd0, 8'h00);
    set_req(1, 1'b1, 5'd6, 8'h66);
    rst = 1'b1;
    #1;
    chk("mid_regwrite_dropped", regwrite, 0);
    chk("mid_ready_in_rst", req_ready, 0);
    cyc();
    rst = 1'b0;
    req_valid = '0;
    chk("mid_after_regwrite", regwrite, 0);
    chk("mid_err_cleared", err_oor, 0);
    cyc();
    chk("rf5_untouched", rf[5], 0);
    chk("rf6_untouched", rf[6], 0);
    req_valid = 3'b111;
    #1;
    chk("mid_ptr_zero", grant_id, 0);
    cyc();
    req_valid = '0;
`else
    set_req(2, 1'b1, 5'd7, 8'h3C);
    #1;
    chk("comb_ready", req_ready, 3'b100);
    chk("comb_regwrite", regwrite, 1);
    chk("comb_wa", wa, 7);
    chk("comb_wd", wd, 8'h3C);
    cyc();
    req_valid = '0;
    #1;
    chk("comb_idle_regwrite", regwrite, 0);
    chk("comb_idle_wa", wa, 0);
    chk("comb_idle_wd", wd, 0);
    chk("comb_rf7", rf[7], 8'h3C);
    set_req(0, 1'b1, 5'd0, 8'hFF);
    #1;
    chk("comb_zero_ready", req_ready, 3'b001);
    chk("comb_zero_no_write", regwrite, 0);
    cyc();
    req_valid = '0;
`endif
    cyc();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
